// File: rtl/glitc_atten_loader.sv
// Serial loader for step attenuators: a register file of per-channel settings
// shifted out over a shared data/clock pair with a per-channel latch enable.
module glitc_atten_loader #(
    parameter int unsigned    NCH      = 6,
    parameter int unsigned    NBITS    = 6,
    parameter int unsigned    CLKDIV   = 4,
    parameter logic [NCH-1:0] INV_MASK = {NCH{1'b1}},
    parameter logic [NCH-1:0] REV_MASK = NCH'((32'd1 << NCH) - (32'd1 << (NCH / 2)))
) (
    input  logic             user_clk_i,
    input  logic             user_rst_n_i,
    input  logic             user_sel_i,
    input  logic             user_wr_i,
    input  logic [3:0]       user_addr_i,
    input  logic [31:0]      user_dat_i,
    output logic [31:0]      user_dat_o,
    output logic             att_d_o,
    output logic             att_clk_o,
    output logic [NCH-1:0]   att_le_o,
    output logic             busy_o
);

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned BW  = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int unsigned CW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    localparam logic [CW-1:0] CntLast  = CW'(CLKDIV - 1);
    localparam logic [BW-1:0] BitLast  = BW'(NBITS - 1);
    localparam logic [3:0]    NchAddr  = 4'(NCH);
    localparam logic [3:0]    CtrlAddr = 4'hF;

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatch,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [CHW-1:0]     ch_q, ch_d;
    logic [NBITS-1:0]   word_q, word_d;
    logic [NBITS-1:0]   setting_q [NCH];
    logic [NBITS-1:0]   setting_d [NCH];
    logic [NCH-1:0]     pending_q, pending_d;
    logic               pause_q, pause_d;

    logic               wr_ch, wr_ctl;
    logic [CHW-1:0]     addr_ch;
    logic [CHW-1:0]     pick_ch;
    logic [NBITS-1:0]   pick_raw, pick_word;
    logic               clr_pick;
    logic               cnt_done;

    assign wr_ch   = user_sel_i & user_wr_i & (user_addr_i < NchAddr);
    assign wr_ctl  = user_sel_i & user_wr_i & (user_addr_i == CtrlAddr);
    assign addr_ch = user_addr_i[CHW-1:0];

    // Descending scan so the lowest-index pending channel is the one left standing.
    always_comb begin
        pick_ch = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_ch = CHW'(i);
            end
        end
    end

    always_comb begin
        pick_raw  = setting_q[pick_ch];
        pick_word = pick_raw;
        if (REV_MASK[pick_ch]) begin
            for (int i = 0; i < int'(NBITS); i++) begin
                pick_word[i] = pick_raw[int'(NBITS) - 1 - i];
            end
        end
        if (INV_MASK[pick_ch]) begin
            pick_word = ~pick_word;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        ch_d     = ch_q;
        word_d   = word_q;
        clr_pick = 1'b0;
        cnt_done = (cnt_q == CntLast);
        unique case (state_q)
            StIdle: begin
                if ((|pending_q) && !pause_q) begin
                    state_d  = StShiftLo;
                    cnt_d    = '0;
                    bit_d    = BitLast;
                    ch_d     = pick_ch;
                    word_d   = pick_word;
                    clr_pick = 1'b1;
                end
            end
            StShiftLo: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = StShiftHi;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShiftHi: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    if (bit_q == '0) begin
                        state_d = StLatch;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        state_d = StShiftLo;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLatch: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // User writes and force-reload are applied after the clear so they win a collision.
    always_comb begin
        setting_d = setting_q;
        pending_d = pending_q;
        pause_d   = pause_q;
        if (clr_pick) begin
            pending_d[pick_ch] = 1'b0;
        end
        if (wr_ch) begin
            setting_d[addr_ch] = user_dat_i[NBITS-1:0];
            pending_d[addr_ch] = 1'b1;
        end
        if (wr_ctl) begin
            pause_d = user_dat_i[30];
            if (user_dat_i[0]) begin
                pending_d = '1;
            end
        end
    end

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            ch_q      <= '0;
            word_q    <= '0;
            setting_q <= '{default: '0};
            pending_q <= '0;
            pause_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            ch_q      <= ch_d;
            word_q    <= word_d;
            setting_q <= setting_d;
            pending_q <= pending_d;
            pause_q   <= pause_d;
        end
    end

    // Outputs decode straight from state so reset clears them without waiting for a clock.
    always_comb begin
        busy_o    = (state_q != StIdle);
        att_clk_o = (state_q == StShiftHi);
        att_d_o   = ((state_q == StShiftLo) || (state_q == StShiftHi)) && word_q[bit_q];
        att_le_o  = (state_q == StLatch) ? (NCH'(1) << ch_q) : '0;
    end

    always_comb begin
        user_dat_o = '0;
        if (user_addr_i < NchAddr) begin
            user_dat_o[NBITS-1:0] = setting_q[addr_ch];
        end else if (user_addr_i == CtrlAddr) begin
            user_dat_o[31]      = |pending_q;
            user_dat_o[30]      = pause_q;
            user_dat_o[16]      = busy_o;
            user_dat_o[NCH-1:0] = pending_q;
        end
    end

endmodule

// File: tb/tb_glitc_atten_loader.sv
// Bench for glitc_atten_loader: register vectors, directed serial-transfer cases and
// randomized paused-write rounds checked against a transfer-level model.
module tb_glitc_atten_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic        att_d, att_clk, busy;
    logic [5:0]  att_le;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    glitc_atten_loader #(
        .NCH      (6),
        .NBITS    (6),
        .CLKDIV   (2),
        .INV_MASK (6'b111111),
        .REV_MASK (6'b111000)
    ) dut (
        .user_clk_i   (clk),
        .user_rst_n_i (rst_n),
        .user_sel_i   (sel),
        .user_wr_i    (wr),
        .user_addr_i  (addr),
        .user_dat_i   (wdat),
        .user_dat_o   (rdat),
        .att_d_o      (att_d),
        .att_clk_o    (att_clk),
        .att_le_o     (att_le),
        .busy_o       (busy)
    );

    // ---------------- reference model ----------------
    typedef struct {int ch; logic [5:0] word;} exp_t;
    exp_t        exp_q[$];
    logic [5:0]  m_set [6];
    logic [5:0]  m_pend;
    bit          m_pause;

    // Channels 3..5 are sent LSB-first, every channel is inverted.
    function automatic logic [5:0] conv(input int ch, input logic [5:0] v);
        logic [5:0] r;
        r = v;
        if (ch >= 3) r = {v[0], v[1], v[2], v[3], v[4], v[5]};
        return ~r;
    endfunction

    function automatic logic [31:0] rd_model(input logic [3:0] a);
        if (a < 4'd6) return {26'b0, m_set[a]};
        if (a == 4'hF) return {|m_pend, m_pause, 13'b0, 1'b0, 10'b0, m_pend};
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_set[i] = '0;
        m_pend  = '0;
        m_pause = 1'b0;
        exp_q.delete();
    endtask

    task automatic release_pending();
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            if (m_pend[c]) begin
                e.ch   = c;
                e.word = conv(c, m_set[c]);
                exp_q.push_back(e);
            end
        end
        m_pend = '0;
    endtask

    // ---------------- bus tasks (called at a negedge, return at the next) ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; wdat = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0;
        if (a < 4'd6) begin
            m_set[a]  = d[5:0];
            m_pend[a] = 1'b1;
        end else if (a == 4'hF) begin
            m_pause = d[30];
            if (d[0]) m_pend = '1;
        end
        if (!m_pause) release_pending();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        sel = 1'b1; wr = 1'b0; addr = a;
        #1 d = rdat;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- output monitor ----------------
    typedef struct {int ch; logic [5:0] word; int bits; int le_cyc; int busy_cyc; bit le_ok;} obs_t;
    obs_t obs_q[$];

    initial begin
        obs_t cur;
        logic p_clk, p_busy;
        p_clk = 1'b0; p_busy = 1'b0;
        cur = '{ch: -1, word: '0, bits: 0, le_cyc: 0, busy_cyc: 0, le_ok: 1'b1};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_clk = 1'b0; p_busy = 1'b0;
            end else begin
                if (busy && !p_busy)
                    cur = '{ch: -1, word: '0, bits: 0, le_cyc: 0, busy_cyc: 0, le_ok: 1'b1};
                if (busy) cur.busy_cyc++;
                if (att_clk && !p_clk) begin
                    cur.word = {cur.word[4:0], att_d};
                    cur.bits++;
                end
                if (att_le != '0) begin
                    cur.le_cyc++;
                    if (!$onehot(att_le) || att_clk || att_d || !busy) cur.le_ok = 1'b0;
                    for (int i = 0; i < 6; i++) if (att_le[i]) cur.ch = i;
                end
                if (!busy && p_busy) obs_q.push_back(cur);
                p_clk  = att_clk;
                p_busy = busy;
            end
        end
    end

    // Wait for every expected transfer, allow time for strays, then compare in order.
    task automatic drain(input string tag);
        int   n, cyc;
        obs_t o;
        n = exp_q.size();
        cyc = 0;
        while ((obs_q.size() < n || busy) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_timeout"}, 64'(cyc < 3000), 64'd1);
        repeat (40) @(negedge clk);
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            o = obs_q[i];
            chk($sformatf("%s_x%0d_ch_word", tag, i),
                64'({o.ch[7:0], o.word}), 64'({exp_q[i].ch[7:0], exp_q[i].word}));
            chk($sformatf("%s_x%0d_timing", tag, i),
                64'({o.bits[7:0], o.le_cyc[7:0], o.busy_cyc[7:0], 7'b0, o.le_ok}),
                64'({8'd6, 8'd2, 8'd28, 8'd1}));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // ---------------- register vector table ----------------
    typedef struct {bit w; logic [3:0] a; logic [31:0] d; logic [31:0] e;} vec_t;
    vec_t vt[16];

    initial begin
        logic [31:0] r;
        int          cyc, rises;
        logic        pc;
        bit          quiet;

        vt[0]  = '{1'b0, 4'd0,  32'h0,         32'h0};
        vt[1]  = '{1'b0, 4'd1,  32'h0,         32'h0};
        vt[2]  = '{1'b0, 4'd2,  32'h0,         32'h0};
        vt[3]  = '{1'b0, 4'd3,  32'h0,         32'h0};
        vt[4]  = '{1'b0, 4'd4,  32'h0,         32'h0};
        vt[5]  = '{1'b0, 4'd5,  32'h0,         32'h0};
        vt[6]  = '{1'b0, 4'hF,  32'h0,         32'h0};
        vt[7]  = '{1'b1, 4'hF,  32'h4000_0000, 32'h4000_0000};
        vt[8]  = '{1'b1, 4'd2,  32'hFFFF_FFAB, 32'h0000_002B};
        vt[9]  = '{1'b1, 4'd9,  32'h0000_0012, 32'h0};
        vt[10] = '{1'b0, 4'hF,  32'h0,         32'hC000_0004};
        vt[11] = '{1'b1, 4'hF,  32'h4000_0001, 32'hC000_003F};
        vt[12] = '{1'b1, 4'd14, 32'hFFFF_FFFF, 32'h0};
        vt[13] = '{1'b1, 4'd5,  32'h0000_003F, 32'h0000_003F};
        vt[14] = '{1'b0, 4'd2,  32'h0,         32'h0000_002B};
        vt[15] = '{1'b0, 4'hF,  32'h0,         32'hC000_003F};

        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({att_d, att_clk, att_le, busy}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].w) bus_write(vt[i].a, vt[i].d);
            bus_read(vt[i].a, r);
            chk($sformatf("vec%0d_rd", i), 64'(r), 64'(vt[i].e));
        end
        bus_write(4'hF, 32'h0);
        drain("vec_unpause");

        // Single channel, no reversal: 0x05 -> 111010, le on channel 0.
        bus_write(4'd0, 32'h05);
        chk("ch0_expect_word", 64'(exp_q[0].word), 64'(6'b111010));
        drain("ch0");

        // Reversed channel: 0x05 -> 010111 on channel 3.
        bus_write(4'd3, 32'h05);
        drain("ch3");

        // Pause holds off transfers until cleared.
        bus_write(4'hF, 32'h4000_0000);
        bus_write(4'd1, 32'h3F);
        bus_write(4'd2, 32'h00);
        repeat (40) @(negedge clk);
        chk("pause_quiet", 64'({obs_q.size(), busy}), 64'd0);
        bus_read(4'hF, r);
        chk("pause_status", 64'(r), 64'h0000_0000_C000_0006);
        bus_write(4'hF, 32'h0);
        drain("pause_release");
        bus_read(4'hF, r);
        chk("pause_after", 64'(r), 64'd0);

        // Rewrite during the third shift-high: both values go out in order.
        bus_write(4'd0, 32'h05);
        rises = 0; pc = 1'b0; cyc = 0;
        while (rises < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (att_clk && !pc) rises++;
            pc = att_clk;
        end
        chk("rewrite_wait", 64'(rises), 64'd3);
        bus_write(4'd0, 32'h0A);
        drain("rewrite");

        // User write lands in the same cycle the pending bit is cleared.
        bus_write(4'hF, 32'h4000_0000);
        bus_write(4'd2, 32'h11);
        bus_write(4'hF, 32'h0);
        bus_write(4'd2, 32'h22);
        drain("wr_vs_clear");

        // Force-reload lands in the same cycle the pending bit is cleared.
        bus_write(4'hF, 32'h4000_0000);
        bus_write(4'd1, 32'h07);
        bus_write(4'hF, 32'h0);
        bus_write(4'hF, 32'h1);
        drain("force_vs_clear");

        // Randomized paused-write rounds.
        for (int rnd = 0; rnd < 6; rnd++) begin
            int op;
            logic [3:0] a;
            bus_write(4'hF, 32'h4000_0000);
            for (int k = 0; k < 8; k++) begin
                op = int'($urandom_range(0, 9));
                if (op < 6) begin
                    bus_write(4'($urandom_range(0, 5)), $urandom);
                end else if (op < 8) begin
                    bus_write(4'($urandom_range(6, 14)), $urandom);
                end else if (op == 8) begin
                    bus_write(4'hF, ($urandom & 32'hBFFF_FFFE) | 32'h4000_0001);
                end else begin
                    a = 4'($urandom_range(0, 15));
                    bus_read(a, r);
                    chk($sformatf("rnd%0d_rd%0d", rnd, a), 64'(r), 64'(rd_model(a)));
                end
            end
            bus_read(4'hF, r);
            chk($sformatf("rnd%0d_status", rnd), 64'(r), 64'(rd_model(4'hF)));
            bus_write(4'hF, 32'h0);
            drain($sformatf("rnd%0d", rnd));
            bus_read(4'hF, r);
            chk($sformatf("rnd%0d_idle_status", rnd), 64'(r), 64'd0);
        end

        // Asynchronous reset in the middle of channel 4's shift-high.
        bus_write(4'd4, 32'h15);
        cyc = 0;
        while (!att_clk && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_wait_shift_hi", 64'(att_clk), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 64'({att_d, att_clk, att_le, busy}), 64'd0);
        model_reset();
        @(negedge clk);
        bus_read(4'd4, r);
        chk("rst_setting_cleared", 64'(r), 64'd0);
        bus_read(4'hF, r);
        chk("rst_status_cleared", 64'(r), 64'd0);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (busy || att_clk || att_d || (att_le != '0)) quiet = 1'b0;
        end
        chk("rst_no_activity", 64'(quiet), 64'd1);
        obs_q.delete();
        bus_write(4'd4, 32'h15);
        drain("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/glitc_atten_loader.md
GLITC_ATTEN_LOADER -- requirements
Module: glitc_atten_loader

Interface
REQ-001 The block SHALL have parameter NCH, default 6, meaning number of attenuator channels (1..15).
REQ-002 The block SHALL have parameter NBITS, default 6, meaning attenuator word width (1..16).
REQ-003 The block SHALL have parameter CLKDIV, default 4, meaning att_clk_o half-period in user_clk_i cycles (>=1).
REQ-004 The block SHALL have parameter INV_MASK, default all-ones NCH bits, meaning per-channel invert of shifted data.
REQ-005 The block SHALL have parameter REV_MASK, default {NCH/2 ones, NCH/2 zeros}, meaning per-channel LSB-first bit-order reversal.
REQ-006 The block SHALL have user_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have user_rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have user_sel_i, user_wr_i, inputs, 1 bit each: register select and write strobe.
REQ-009 The block SHALL have user_addr_i, input, 4 bits, and user_dat_i, input, 32 bits: register address and write data.
REQ-010 The block SHALL have user_dat_o, output, 32 bits: combinational readback of the register at user_addr_i.
REQ-011 The block SHALL have att_d_o and att_clk_o, outputs, 1 bit each: shared serial data and clock.
REQ-012 The block SHALL have att_le_o, output, NCH bits: per-channel latch enable.
REQ-013 The block SHALL have busy_o, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-014 Address a < NCH SHALL hold setting[a] = user_dat_i[NBITS-1:0] on write, set pending[a], and read back zero-extended.
REQ-015 Address 15 SHALL be control/status: bit30 pause (r/w), bit16 busy (r), bits NCH-1:0 pending (r), bit31 = |pending (r); writing bit0=1 sets all pending bits.
REQ-016 Unmapped addresses SHALL read 0 and ignore writes.
REQ-017 Transmit word for channel c: reverse the bits if REV_MASK[c], then invert them if INV_MASK[c]; shift MSB first.
REQ-018 FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP.
REQ-019 IDLE: if |pending and !pause, select the lowest-index pending channel, latch its converted word (pre-write register value that cycle), clear its pending bit, and go to SHIFT_LO.
REQ-020 A user write to a channel in the same cycle its pending bit is cleared SHALL win: pending stays set.
REQ-021 SHIFT_LO: att_clk_o=0, att_d_o=current bit, for CLKDIV cycles; then SHIFT_HI: att_clk_o=1, att_d_o held, for CLKDIV cycles.
REQ-022 After SHIFT_HI of the last bit go to LATCH, else SHIFT_LO with the next bit.
REQ-023 LATCH: att_d_o=0, att_clk_o=0, att_le_o[c]=1, for CLKDIV cycles; then GAP: all outputs low for CLKDIV cycles; then IDLE.
REQ-024 One channel transfer SHALL take exactly 2*CLKDIV*(NBITS+1) cycles from leaving IDLE to re-entering IDLE.
REQ-025 Only one att_le_o bit SHALL ever be high, and only in LATCH.
REQ-026 Setting pause mid-transfer SHALL let the current channel complete; no new channel starts while pause=1.
REQ-027 Writing a channel under transfer SHALL not alter the latched word; the new value is sent in a later transfer.
REQ-028 Control-bit0 force and a simultaneous clear SHALL leave all pending bits set.

Reset
REQ-029 While user_rst_n_i=0: FSM IDLE, all settings 0, pending 0, pause 0, att_d_o=att_clk_o=0, att_le_o=0, busy_o=0, asynchronously, including mid-transfer.
REQ-030 After reset release, no transfer SHALL start until a setting write or force-reload.

Verification (NCH=6, NBITS=6, CLKDIV=2, INV_MASK=6'b111111, REV_MASK=6'b111000)
REQ-031 Reset -> all outputs 0; reads of addr 0..5 and 15 return 0x00000000.
REQ-032 Write addr0=0x05 -> att_d_o bits 1,1,1,0,1,0 sampled on att_clk_o rising; att_le_o=6'b000001 for 2 cycles; busy_o high exactly 28 cycles.
REQ-033 Write addr3=0x05 -> reversed then inverted word 6'b010111; att_d_o bits 0,1,0,1,1,1; att_le_o[3] pulses 2 cycles.
REQ-034 Write addr15 bit30=1, then addr1=0x3F, addr2=0x00 -> no att activity, addr15 reads 0xC0000006; write addr15=0 -> ch1 transfer then ch2 transfer, pending reads 0.
REQ-035 Write addr0=0x05, then addr0=0x0A during SHIFT_HI of bit 2 -> first transfer sends 111010, second sends 110101, then idle.
REQ-036 Assert user_rst_n_i during SHIFT_HI of ch4 -> att_clk_o, att_d_o, att_le_o, busy_o low in the same cycle; after release no activity until a write.
